// File: rtl/local_out_port_buffer.sv
// Router local output port stage: buffers crossbar packets in a small FIFO and hands them one at a time to the Collector.
// Define LOCAL_OUT_STATS_EN to add the DeliveredCnt and MaxCount statistics outputs.
module local_out_port_buffer #(
    parameter logic [5:0] routerID    = 6'b100_000,
    parameter int         packetwidth = 26,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         ADDR_W      = 2,
    parameter int         GNT_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [packetwidth-1:0] PacketIn,
    input  logic                   ReqUpStr,
    output logic                   GntUpStr,
    output logic                   UpStrFull,
    output logic [packetwidth-1:0] PacketOut,
    output logic                   ReqDnStr,
    input  logic                   GntDnStr,
    input  logic                   DnStrFull,
    output logic [ADDR_W:0]        Count,
`ifdef LOCAL_OUT_STATS_EN
    output logic [15:0]            DeliveredCnt,
    output logic [ADDR_W:0]        MaxCount,
`endif
    output logic                   TimeoutErr
);

    localparam int              TMR_W   = $clog2(GNT_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(GNT_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GNT_TIMEOUT - 1);
    localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {I_WAIT, I_GNT} ingState_t;
    typedef enum logic {E_IDLE, E_REQ} egrState_t;

    logic [packetwidth-1:0] mem_q [FIFO_DEPTH];

    logic [ADDR_W:0]        wrPtr_q, wrPtr_d;
    logic [ADDR_W:0]        rdPtr_q, rdPtr_d;
    ingState_t              ingState_q, ingState_d;
    egrState_t              egrState_q, egrState_d;
    logic                   gntUp_q, gntUp_d;
    logic                   reqDn_q, reqDn_d;
    logic [packetwidth-1:0] pktOut_q, pktOut_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic                   timeoutErr_q, timeoutErr_d;

    logic [ADDR_W:0]        count;
    logic                   full;
    logic                   wrEn;
    logic                   popEn;

    // Occupancy and full are decoded from the pointer registers only.
    assign count = wrPtr_q - rdPtr_q;
    assign full  = (count == DEPTH_C);

    always_comb begin
        ingState_d = ingState_q;
        gntUp_d    = 1'b0;
        wrEn       = 1'b0;
        case (ingState_q)
            I_WAIT: begin
                if (ReqUpStr && !full) begin
                    wrEn       = 1'b1;
                    gntUp_d    = 1'b1;
                    ingState_d = I_GNT;
                end
            end
            I_GNT: begin
                ingState_d = I_WAIT;
            end
            default: begin
                ingState_d = I_WAIT;
            end
        endcase
    end

    // The request stays up through a timeout; the flag is only a sticky report.
    always_comb begin
        egrState_d   = egrState_q;
        reqDn_d      = reqDn_q;
        pktOut_d     = pktOut_q;
        timer_d      = timer_q;
        timeoutErr_d = timeoutErr_q;
        popEn        = 1'b0;
        case (egrState_q)
            E_IDLE: begin
                if ((count != '0) && !DnStrFull) begin
                    pktOut_d   = mem_q[rdPtr_q[ADDR_W-1:0]];
                    reqDn_d    = 1'b1;
                    timer_d    = '0;
                    egrState_d = E_REQ;
                end
            end
            E_REQ: begin
                if (GntDnStr) begin
                    popEn      = 1'b1;
                    reqDn_d    = 1'b0;
                    egrState_d = E_IDLE;
                end else begin
                    if (timer_q != TMR_MAX) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                    if (timer_q == TMR_LAST) begin
                        timeoutErr_d = 1'b1;
                    end
                end
            end
            default: begin
                egrState_d = E_IDLE;
            end
        endcase
    end

    assign wrPtr_d = wrPtr_q + (ADDR_W + 1)'(wrEn);
    assign rdPtr_d = rdPtr_q + (ADDR_W + 1)'(popEn);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            ingState_q   <= I_WAIT;
            egrState_q   <= E_IDLE;
            gntUp_q      <= 1'b0;
            reqDn_q      <= 1'b0;
            pktOut_q     <= '0;
            timer_q      <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            ingState_q   <= ingState_d;
            egrState_q   <= egrState_d;
            gntUp_q      <= gntUp_d;
            reqDn_q      <= reqDn_d;
            pktOut_q     <= pktOut_d;
            timer_q      <= timer_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    // Storage has no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrPtr_q[ADDR_W-1:0]] <= PacketIn;
        end
    end

`ifdef LOCAL_OUT_STATS_EN
    logic [15:0]     delivered_q;
    logic [ADDR_W:0] maxCount_q;
    logic [ADDR_W:0] countNext;

    assign countNext = wrPtr_d - rdPtr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delivered_q <= '0;
            maxCount_q  <= '0;
        end else begin
            delivered_q <= delivered_q + 16'(popEn);
            if (countNext > maxCount_q) begin
                maxCount_q <= countNext;
            end
        end
    end

    assign DeliveredCnt = delivered_q;
    assign MaxCount     = maxCount_q;
`endif

    assign GntUpStr   = gntUp_q;
    assign UpStrFull  = full;
    assign PacketOut  = pktOut_q;
    assign ReqDnStr   = reqDn_q;
    assign Count      = count;
    assign TimeoutErr = timeoutErr_q;

endmodule
